// File: rtl/unconnected_port_responder.sv
// Stand-in slave for an open request/response port: accepts every request and answers
// each one after a fixed delay with default read data and a configurable error flag.
module unconnected_port_responder #(
  parameter int unsigned                DATA_WIDTH      = 32,
  parameter int unsigned                ADDR_WIDTH      = 16,
  parameter int unsigned                LATENCY         = 1,
  parameter logic [DATA_WIDTH-1:0]      DEFAULT_DATA    = '0,
  parameter bit                         ERROR_ON_ACCESS = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_error,
  output logic [31:0]           o_req_count,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StDelay, StResp} state_e;

  localparam logic [7:0] LatLoad = 8'(LATENCY);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] count_q, count_d;

  // Address and write data are accepted but intentionally never used.
  logic unused_req;
  assign unused_req = ^{i_req_addr, i_req_wdata};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          write_d = i_req_write;
          cnt_d   = LatLoad;
          state_d = (LatLoad == 8'd0) ? StResp : StDelay;
          if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        end
      end
      StDelay: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = StResp;
      end
      StResp: begin
        if (i_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode registered state only; nothing passes through from inputs.
  always_comb begin
    o_req_ready = (state_q == StIdle);
    o_rsp_valid = (state_q == StResp);
    o_busy      = (state_q != StIdle);
    o_rsp_error = o_rsp_valid & ERROR_ON_ACCESS;
    o_rsp_data  = '0;
    if (o_rsp_valid && !write_q) o_rsp_data = DEFAULT_DATA;
    o_req_count = count_q;
  end

endmodule

// File: tb/tb_unconnected_port_responder.sv
// Directed bench for unconnected_port_responder: three instances cover LATENCY 1, 0 and 3
// sharing one stimulus bus, each checked with hand-computed expectations.
module tb_unconnected_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  logic [2:0]  ready_o, valid_o, err_o, busy_o;
  logic [31:0] data_o [3];
  logic [31:0] cnt_o  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unconnected_port_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .LATENCY(1),
    .DEFAULT_DATA(32'h0000_1234), .ERROR_ON_ACCESS(1'b1)
  ) u0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready_o[0]),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(valid_o[0]), .i_rsp_ready(rsp_ready), .o_rsp_data(data_o[0]),
    .o_rsp_error(err_o[0]), .o_req_count(cnt_o[0]), .o_busy(busy_o[0])
  );

  unconnected_port_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .LATENCY(0),
    .DEFAULT_DATA(32'hA5A5_0001), .ERROR_ON_ACCESS(1'b0)
  ) u1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready_o[1]),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(valid_o[1]), .i_rsp_ready(rsp_ready), .o_rsp_data(data_o[1]),
    .o_rsp_error(err_o[1]), .o_req_count(cnt_o[1]), .o_busy(busy_o[1])
  );

  unconnected_port_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .LATENCY(3),
    .DEFAULT_DATA(32'h0000_0000), .ERROR_ON_ACCESS(1'b1)
  ) u2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready_o[2]),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(valid_o[2]), .i_rsp_ready(rsp_ready), .o_rsp_data(data_o[2]),
    .o_rsp_error(err_o[2]), .o_req_count(cnt_o[2]), .o_busy(busy_o[2])
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accept edge.
  task automatic do_req(input logic wr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_wdata = wd; req_addr = 16'h00F0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready_o[i] !== 1'b1 || valid_o[i] !== 1'b0 || err_o[i] !== 1'b0 ||
          busy_o[i] !== 1'b0 || data_o[i] !== 32'h0 || cnt_o[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_vals u%0d: rdy=%b vld=%b err=%b busy=%b data=%h cnt=%0d, need 1 0 0 0 0 0",
                 i, ready_o[i], valid_o[i], err_o[i], busy_o[i], data_o[i], cnt_o[i]);
      end
    end
    req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    apply_reset();
    rsp_ready = 1'b1;
    do_req(1'b0, 32'h0);
    checks++;
    if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b1 || ready_o[0] !== 1'b0 || cnt_o[0] !== 32'd1) begin
      errors++;
      $display("FAIL read_delay: vld=%b busy=%b rdy=%b cnt=%0d, need 0 1 0 1",
               valid_o[0], busy_o[0], ready_o[0], cnt_o[0]);
    end
    checks++;
    if (valid_o[1] !== 1'b1 || err_o[1] !== 1'b0 || data_o[1] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL lat0_resp: vld=%b err=%b data=%h, need 1 0 a5a50001",
               valid_o[1], err_o[1], data_o[1]);
    end
    @(negedge clk);
    checks++;
    if (valid_o[0] !== 1'b1 || data_o[0] !== 32'h0000_1234 || err_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL read_resp: vld=%b data=%h err=%b, need 1 00001234 1",
               valid_o[0], data_o[0], err_o[0]);
    end
    @(negedge clk);
    checks++;
    if (valid_o[0] !== 1'b0 || data_o[0] !== 32'h0 || err_o[0] !== 1'b0 || ready_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL read_done: vld=%b data=%h err=%b rdy=%b, need 0 0 0 1",
               valid_o[0], data_o[0], err_o[0], ready_o[0]);
    end
  endtask

  task automatic test_write_then_read();
    apply_reset();
    rsp_ready = 1'b1;
    do_req(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (valid_o[0] !== 1'b1 || data_o[0] !== 32'h0 || err_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_resp: vld=%b data=%h err=%b, need 1 0 1", valid_o[0], data_o[0], err_o[0]);
    end
    @(negedge clk);
    do_req(1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (valid_o[0] !== 1'b1 || data_o[0] !== 32'h0000_1234 || cnt_o[0] !== 32'd2) begin
      errors++;
      $display("FAIL read_after_write: vld=%b data=%h cnt=%0d, need 1 00001234 2",
               valid_o[0], data_o[0], cnt_o[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    apply_reset();
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (valid_o[1] !== 1'b1 || data_o[1] !== 32'hA5A5_0001 || ready_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d: vld=%b data=%h rdy=%b, need 1 a5a50001 0",
                 c, valid_o[1], data_o[1], ready_o[1]);
      end
      @(negedge clk);
    end
    checks++;
    if (cnt_o[1] !== 32'd1) begin
      errors++;
      $display("FAIL stall_count: cnt=%0d, need 1", cnt_o[1]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o[1] !== 1'b0 || ready_o[1] !== 1'b1 || data_o[1] !== 32'h0) begin
      errors++;
      $display("FAIL stall_release: vld=%b rdy=%b data=%h, need 0 1 0",
               valid_o[1], ready_o[1], data_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rsp_ready = 1'b1; req_write = 1'b0;
    req_valid = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 4) begin
        checks++;
        if (valid_o[2] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_rsp_edge4: vld=%b, need 1", valid_o[2]);
        end
      end
      if (e == 5 || e == 6) begin
        checks++;
        if (cnt_o[2] !== 32'(e - 4)) begin
          errors++;
          $display("FAIL b2b_count_edge%0d: cnt=%0d, need %0d", e, cnt_o[2], e - 4);
        end
      end
    end
    checks++;
    if (cnt_o[2] !== 32'd4) begin
      errors++;
      $display("FAIL b2b_count_20: cnt=%0d, need 4", cnt_o[2]);
    end
    checks++;
    if (cnt_o[1] !== 32'd10) begin
      errors++;
      $display("FAIL b2b_lat0_count_20: cnt=%0d, need 10", cnt_o[1]);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_in_delay();
    bit seen;
    apply_reset();
    rsp_ready = 1'b1;
    do_req(1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy_o[2] !== 1'b1 || valid_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_delay: busy=%b vld=%b, need 1 0", busy_o[2], valid_o[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready_o[2] !== 1'b1 || valid_o[2] !== 1'b0 || busy_o[2] !== 1'b0 ||
        cnt_o[2] !== 32'h0 || data_o[2] !== 32'h0 || err_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_delay: rdy=%b vld=%b busy=%b cnt=%0d data=%h err=%b, need 1 0 0 0 0 0",
               ready_o[2], valid_o[2], busy_o[2], cnt_o[2], data_o[2], err_o[2]);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_o[2] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || cnt_o[2] !== 32'h0) begin
      errors++;
      $display("FAIL no_ghost_resp: seen=%b cnt=%0d, need 0 0", seen, cnt_o[2]);
    end
  endtask

  task automatic test_saturate();
    int waited;
    apply_reset();
    rsp_ready = 1'b1;
    @(negedge clk);
    force u0.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release u0.count_q;
    @(negedge clk);
    checks++;
    if (cnt_o[0] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sat_preload: cnt=%h, need fffffffe", cnt_o[0]);
    end
    for (int r = 0; r < 3; r++) begin
      do_req(1'b0, 32'h0);
      waited = 0;
      while (ready_o[0] !== 1'b1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (waited >= 10 || cnt_o[0] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL sat_req%0d: cnt=%h waited=%0d, need ffffffff within 10", r, cnt_o[0], waited);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_stall();
    test_back_to_back();
    test_reset_in_delay();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
